// File: rtl/vec_decode_pkg.sv
// Shared types for the buffered vector decode stage: opcode encoding, the packed
// datapath control bundle, its idle value and the opcode decode helpers.
package vec_decode_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [OPC_W-1:0] {
    VLOAD  = 5'd0,
    VSTORE = 5'd1,
    VADD   = 5'd2,
    VSUB   = 5'd3,
    VMUL   = 5'd4,
    VAND   = 5'd5,
    VOR    = 5'd6,
    VXOR   = 5'd7,
    VCMP   = 5'd8,
    VSADD  = 5'd9,
    VFSADD = 5'd10
  } opcode_e;

  typedef struct packed {
    logic       mux_sel;
    logic       vreg_we;
    logic       preg_we;
    logic       sreg_we;
    logic       vload_mux;
    logic       sload_mux;
    logic [2:0] fu_sel;
    logic       add_sub;
    logic       load_store;
    logic       clk_en;
    logic       clk_bypass;
    logic [1:0] bitwise_sel;
    logic [3:0] pred_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mux_sel: 1'b0, vreg_we: 1'b0, preg_we: 1'b0, sreg_we: 1'b0,
                                  vload_mux: 1'b0, sload_mux: 1'b0, fu_sel: 3'd0,
                                  add_sub: 1'b0, load_store: 1'b0, clk_en: 1'b0,
                                  clk_bypass: 1'b1, bitwise_sel: 2'd0, pred_sel: 4'd0};

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return opc <= VFSADD;
  endfunction

  // Every legal op except VLOAD consumes vector register operands.
  function automatic logic reads_vregs(input logic [OPC_W-1:0] opc);
    return is_legal(opc) && (opc != VLOAD);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opc);
    ctrl_t c;
    c = CTRL_IDLE;
    if (is_legal(opc)) begin
      c.clk_en     = 1'b1;
      c.clk_bypass = 1'b0;
    end
    case (opc)
      VLOAD:  begin c.vreg_we = 1'b1; c.vload_mux = 1'b1; c.fu_sel = 3'd4; end
      VSTORE: begin c.load_store = 1'b1; c.fu_sel = 3'd4; end
      VADD:   begin c.vreg_we = 1'b1; end
      VSUB:   begin c.vreg_we = 1'b1; c.add_sub = 1'b1; end
      VMUL:   begin c.vreg_we = 1'b1; c.fu_sel = 3'd1; end
      VAND:   begin c.vreg_we = 1'b1; c.fu_sel = 3'd2; c.bitwise_sel = 2'd0; end
      VOR:    begin c.vreg_we = 1'b1; c.fu_sel = 3'd2; c.bitwise_sel = 2'd1; end
      VXOR:   begin c.vreg_we = 1'b1; c.fu_sel = 3'd2; c.bitwise_sel = 2'd2; end
      VCMP:   begin c.preg_we = 1'b1; c.fu_sel = 3'd3; c.pred_sel = 4'b0001; end
      VSADD:  begin c.vreg_we = 1'b1; c.mux_sel = 1'b1; end
      VFSADD: begin c.sreg_we = 1'b1; c.sload_mux = 1'b1; c.fu_sel = 3'd5; end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vec_decode_stage_fifo.sv
// Parametrised synchronous instruction FIFO with occupancy count and a registered
// full flag; flush empties it and overrides any same-cycle push or pop.
module vec_ibuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // No write-through: a full FIFO refuses pushes even when it pops this cycle.
  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/vec_decode_stage.sv
// Buffered vector decode stage: FIFO-queued instructions, registered decoded bundle with
// valid/ready handshake. Define VEC_DECODE_SCOREBOARD_EN to stall RAW/WAW hazards.
module vec_decode_stage
  import vec_decode_pkg::*;
#(
  parameter int IBUF_DEPTH = 4,
  parameter int REG_AW     = 5,
  parameter int NUM_VREGS  = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush_i,
  input  logic [31:0]                   instr_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output ctrl_t                         dec_ctrl_o,
  output logic [REG_AW-1:0]             dec_vd_o,
  output logic [REG_AW-1:0]             dec_vs1_o,
  output logic [REG_AW-1:0]             dec_vs2_o,
  output logic                          dec_illegal_o,
  input  logic                          wb_valid_i,
  input  logic [REG_AW-1:0]             wb_vd_i,
  output logic [$clog2(IBUF_DEPTH):0]   ibuf_count_o
);

  logic [31:0]       head;
  logic              head_empty;
  logic              fifo_full;
  logic              load;
  logic              stall;
  logic [OPC_W-1:0]  head_opc;
  logic [REG_AW-1:0] head_vd, head_vs1, head_vs2;
  logic              head_legal;
  ctrl_t             head_ctrl;

  logic              dec_valid_q, dec_valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic              illegal_q, illegal_d;
  logic              unused_head;

  vec_ibuf_fifo #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH (32)
  ) u_ibuf (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush_i),
    .push_i  (instr_valid_i),
    .pop_i   (load),
    .wdata_i (instr_i),
    .rdata_o (head),
    .empty_o (head_empty),
    .full_o  (fifo_full),
    .count_o (ibuf_count_o)
  );

  assign head_opc    = head[31:27];
  assign head_vd     = head[21 +: REG_AW];
  assign head_vs1    = head[16 +: REG_AW];
  assign head_vs2    = head[11 +: REG_AW];
  assign head_legal  = is_legal(head_opc);
  assign head_ctrl   = decode_ctrl(head_opc);
  assign unused_head = ^{head[26], head[10:0]};

  assign load = !head_empty && !stall && (!dec_valid_q || dec_ready_i);

`ifdef VEC_DECODE_SCOREBOARD_EN
  logic [NUM_VREGS-1:0] pending_q, pending_d, pending_eff;

  // A writeback arriving this cycle already unblocks the head, so the waiter
  // issues on the same edge that clears its pending bit.
  always_comb begin
    pending_eff = pending_q;
    if (wb_valid_i) pending_eff[wb_vd_i] = 1'b0;
    stall = (reads_vregs(head_opc) && (pending_eff[head_vs1] || pending_eff[head_vs2])) ||
            (head_ctrl.vreg_we && pending_eff[head_vd]);
    pending_d = pending_eff;
    if (load && head_ctrl.vreg_we) pending_d[head_vd] = 1'b1;
    if (flush_i) pending_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end
`else
  localparam int UNUSED_NUM_VREGS = NUM_VREGS;
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_vd_i, UNUSED_NUM_VREGS[0]};
  assign stall     = 1'b0;
`endif

  always_comb begin
    dec_valid_d = dec_valid_q;
    ctrl_d      = ctrl_q;
    vd_d        = vd_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    illegal_d   = illegal_q;
    if (flush_i) begin
      dec_valid_d = 1'b0;
      ctrl_d      = CTRL_IDLE;
      vd_d        = '0;
      vs1_d       = '0;
      vs2_d       = '0;
      illegal_d   = 1'b0;
    end else if (load) begin
      dec_valid_d = 1'b1;
      ctrl_d      = head_ctrl;
      vd_d        = head_legal ? head_vd  : '0;
      vs1_d       = head_legal ? head_vs1 : '0;
      vs2_d       = head_legal ? head_vs2 : '0;
      illegal_d   = !head_legal;
    end else if (dec_ready_i) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_valid_q <= 1'b0;
      ctrl_q      <= CTRL_IDLE;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      dec_valid_q <= dec_valid_d;
      ctrl_q      <= ctrl_d;
      vd_q        <= vd_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready_o = !fifo_full;
  assign dec_valid_o   = dec_valid_q;
  assign dec_ctrl_o    = ctrl_q;
  assign dec_vd_o      = vd_q;
  assign dec_vs1_o     = vs1_q;
  assign dec_vs2_o     = vs2_q;
  assign dec_illegal_o = illegal_q;

endmodule

// File: tb/tb_vec_decode_stage.sv
// Testbench for vec_decode_stage: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Scoreboard scenario needs VEC_DECODE_SCOREBOARD_EN.
module tb_vec_decode_stage;
  import vec_decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        dec_ready_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_vd_i = '0;
  logic        instr_ready_o, dec_valid_o, dec_illegal_o;
  ctrl_t       dec_ctrl_o;
  logic [4:0]  dec_vd_o, dec_vs1_o, dec_vs2_o;
  logic [2:0]  ibuf_count_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_decode_stage #(.IBUF_DEPTH(DEPTH), .REG_AW(5), .NUM_VREGS(NV)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_ctrl_o    (dec_ctrl_o),
    .dec_vd_o      (dec_vd_o),
    .dec_vs1_o     (dec_vs1_o),
    .dec_vs2_o     (dec_vs2_o),
    .dec_illegal_o (dec_illegal_o),
    .wb_valid_i    (wb_valid_i),
    .wb_vd_i       (wb_vd_i),
    .ibuf_count_o  (ibuf_count_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy);
    instr_valid_i = v;
    instr_i       = ins;
    dec_ready_i   = rdy;
    @(negedge clk);
  endtask

  task automatic flushPulse();
    flush_i = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1);
    flush_i = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] o, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {o, 1'b0, d, s1, s2, 11'd0};
  endfunction

  // Reference decode table, one row per opcode.
  function automatic logic legal_opc(input logic [4:0] o);
    return o <= 5'd10;
  endfunction

  function automatic logic writes_v(input logic [4:0] o);
    return o inside {5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9};
  endfunction

  function automatic logic reads_v(input logic [4:0] o);
    return legal_opc(o) && (o != 5'd0);
  endfunction

  function automatic ctrl_t exp_ctrl(input logic [4:0] o);
    ctrl_t c;
    c = '0;
    c.clk_bypass = !legal_opc(o);
    c.clk_en     = legal_opc(o);
    c.vreg_we    = writes_v(o);
    case (o)
      5'd0:  begin c.vload_mux = 1'b1; c.fu_sel = 3'd4; end
      5'd1:  begin c.load_store = 1'b1; c.fu_sel = 3'd4; end
      5'd3:  c.add_sub = 1'b1;
      5'd4:  c.fu_sel = 3'd1;
      5'd5:  c.fu_sel = 3'd2;
      5'd6:  begin c.fu_sel = 3'd2; c.bitwise_sel = 2'd1; end
      5'd7:  begin c.fu_sel = 3'd2; c.bitwise_sel = 2'd2; end
      5'd8:  begin c.preg_we = 1'b1; c.fu_sel = 3'd3; c.pred_sel = 4'd1; end
      5'd9:  c.mux_sel = 1'b1;
      5'd10: begin c.sreg_we = 1'b1; c.sload_mux = 1'b1; c.fu_sel = 3'd5; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic model_stall(input logic [31:0] ins, input logic [NV-1:0] p);
`ifdef VEC_DECODE_SCOREBOARD_EN
    return (reads_v(ins[31:27]) && (p[ins[20:16]] || p[ins[15:11]])) ||
           (writes_v(ins[31:27]) && p[ins[25:21]]);
`else
    return 1'b0 && ins[0] && p[0];
`endif
  endfunction

  logic [31:0]   mq[$];
  logic          m_valid = 1'b0;
  logic [31:0]   m_instr = '0;
  logic [NV-1:0] m_pend = '0;

  always @(posedge clk or negedge reset_n) begin : model_p
    logic [NV-1:0] pe;
    logic          was_ready;
    logic [31:0]   h;
    if (!reset_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_pend  = '0;
    end else begin
      was_ready = (mq.size() < DEPTH);
      if (flush_i) begin
        mq.delete();
        m_valid = 1'b0;
        m_pend  = '0;
      end else begin
        pe = m_pend;
        if (wb_valid_i) pe[wb_vd_i] = 1'b0;
        if (mq.size() > 0 && !model_stall(mq[0], pe) && (!m_valid || dec_ready_i)) begin
          h = mq.pop_front();
          m_instr = h;
          m_valid = 1'b1;
          if (writes_v(h[31:27])) pe[h[25:21]] = 1'b1;
        end else if (dec_ready_i) begin
          m_valid = 1'b0;
        end
        if (instr_valid_i && was_ready) mq.push_back(instr_i);
        m_pend = pe;
      end
    end
  end

  always @(negedge clk) begin : compare_p
    logic lg;
    if (reset_n) begin
      checkOutput("instr_ready", 32'(instr_ready_o), 32'(mq.size() < DEPTH));
      checkOutput("ibuf_count", 32'(ibuf_count_o), 32'(mq.size()));
      checkOutput("dec_valid", 32'(dec_valid_o), 32'(m_valid));
      if (m_valid) begin
        lg = legal_opc(m_instr[31:27]);
        checkOutput("dec_illegal", 32'(dec_illegal_o), 32'(!lg));
        checkOutput("dec_ctrl", 32'(dec_ctrl_o), 32'(exp_ctrl(m_instr[31:27])));
        checkOutput("dec_vd", 32'(dec_vd_o), lg ? 32'(m_instr[25:21]) : 32'd0);
        checkOutput("dec_vs1", 32'(dec_vs1_o), lg ? 32'(m_instr[20:16]) : 32'd0);
        checkOutput("dec_vs2", 32'(dec_vs2_o), lg ? 32'(m_instr[15:11]) : 32'd0);
      end
    end
  end

  logic [4:0] t2_opc [5] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd7};

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("rst_ready", 32'(instr_ready_o), 32'd1);
    checkOutput("rst_count", 32'(ibuf_count_o), 32'd0);
    checkOutput("rst_ctrl", 32'(dec_ctrl_o), 32'h00040);
    checkOutput("rst_illegal", 32'(dec_illegal_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single VADD: visible two cycles after the push.
    applyStimulus(1'b1, mk(5'd2, 5'd3, 5'd1, 5'd2), 1'b1);
    checkOutput("t1_valid_n1", 32'(dec_valid_o), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t1_valid_n2", 32'(dec_valid_o), 32'd1);
    checkOutput("t1_fu_sel", 32'(dec_ctrl_o.fu_sel), 32'd0);
    checkOutput("t1_add_sub", 32'(dec_ctrl_o.add_sub), 32'd0);
    checkOutput("t1_vreg_we", 32'(dec_ctrl_o.vreg_we), 32'd1);
    checkOutput("t1_clk_en", 32'(dec_ctrl_o.clk_en), 32'd1);
    checkOutput("t1_vd", 32'(dec_vd_o), 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t1_drained", 32'(dec_valid_o), 32'd0);
    flushPulse();

    // Back-pressure: five pushes fill register plus FIFO, sixth is refused.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, mk(t2_opc[k], 5'(10 + k), 5'd0, 5'd0), 1'b0);
    checkOutput("t2_count_full", 32'(ibuf_count_o), 32'd4);
    checkOutput("t2_ready_low", 32'(instr_ready_o), 32'd0);
    applyStimulus(1'b1, mk(5'd2, 5'd20, 5'd0, 5'd0), 1'b0);
    checkOutput("t2_count_held", 32'(ibuf_count_o), 32'd4);
    checkOutput("t2_bundle_held", 32'(dec_vd_o), 32'd10);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t2_order_valid", 32'(dec_valid_o), 32'd1);
      checkOutput("t2_order_vd", 32'(dec_vd_o), 32'(10 + k));
      applyStimulus(1'b0, 32'd0, 1'b1);
    end
    checkOutput("t2_empty_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("t2_empty_count", 32'(ibuf_count_o), 32'd0);
    flushPulse();

    // Illegal opcode issues as an idle bundle, then VSUB follows.
    applyStimulus(1'b1, mk(5'h1f, 5'd7, 5'd8, 5'd9), 1'b1);
    applyStimulus(1'b1, mk(5'd3, 5'd5, 5'd1, 5'd2), 1'b1);
    checkOutput("t3_ill_valid", 32'(dec_valid_o), 32'd1);
    checkOutput("t3_ill_flag", 32'(dec_illegal_o), 32'd1);
    checkOutput("t3_ill_ctrl", 32'(dec_ctrl_o), 32'h00040);
    checkOutput("t3_ill_vd", 32'(dec_vd_o), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t3_sub_flag", 32'(dec_illegal_o), 32'd0);
    checkOutput("t3_sub_add_sub", 32'(dec_ctrl_o.add_sub), 32'd1);
    checkOutput("t3_sub_vd", 32'(dec_vd_o), 32'd5);
    applyStimulus(1'b0, 32'd0, 1'b1);
    flushPulse();

`ifdef VEC_DECODE_SCOREBOARD_EN
    // RAW hazard on v4 holds VADD until the VMUL writeback.
    applyStimulus(1'b1, mk(5'd4, 5'd4, 5'd1, 5'd2), 1'b1);
    applyStimulus(1'b1, mk(5'd2, 5'd6, 5'd4, 5'd2), 1'b1);
    checkOutput("t4_vmul_vd", 32'(dec_vd_o), 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t4_stall_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("t4_stall_count", 32'(ibuf_count_o), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t4_still_stalled", 32'(dec_valid_o), 32'd0);
    wb_valid_i = 1'b1;
    wb_vd_i    = 5'd4;
    applyStimulus(1'b0, 32'd0, 1'b1);
    wb_valid_i = 1'b0;
    checkOutput("t4_release_valid", 32'(dec_valid_o), 32'd1);
    checkOutput("t4_release_vs1", 32'(dec_vs1_o), 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    flushPulse();
`endif

    // Flush with three queued and a bundle held; same-cycle push is dropped.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, mk(5'd2, 5'(k + 1), 5'd0, 5'd0), 1'b0);
    checkOutput("t5_pre_count", 32'(ibuf_count_o), 32'd3);
    checkOutput("t5_pre_valid", 32'(dec_valid_o), 32'd1);
    flush_i = 1'b1;
    applyStimulus(1'b1, mk(5'd3, 5'd9, 5'd0, 5'd0), 1'b0);
    flush_i = 1'b0;
    checkOutput("t5_count", 32'(ibuf_count_o), 32'd0);
    checkOutput("t5_valid", 32'(dec_valid_o), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("t5_push_dropped", 32'(ibuf_count_o), 32'd0);

    // Asynchronous reset mid-stream, then resume.
    applyStimulus(1'b1, mk(5'd2, 5'd1, 5'd0, 5'd0), 1'b1);
    applyStimulus(1'b1, mk(5'd3, 5'd2, 5'd0, 5'd0), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("t6_count", 32'(ibuf_count_o), 32'd0);
    checkOutput("t6_ready", 32'(instr_ready_o), 32'd1);
    checkOutput("t6_ctrl", 32'(dec_ctrl_o), 32'h00040);
    checkOutput("t6_vd", 32'(dec_vd_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, mk(5'd4, 5'd7, 5'd0, 5'd0), 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t6_resume_valid", 32'(dec_valid_o), 32'd1);
    checkOutput("t6_resume_vd", 32'(dec_vd_o), 32'd7);
    checkOutput("t6_resume_fu", 32'(dec_ctrl_o.fu_sel), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
